// File: rtl/mem_access_scheduler.sv
// Dual-lane load/store scheduler in front of a two-port data memory.
// Same-word pairs that involve a store are split over two cycles: lane 1
// first, lane 2 from holding registers. Out-of-range addresses complete
// with a fault and never reach the memory.
module mem_access_scheduler #(
  parameter int unsigned ADDR_MAX = 999,
  // ceiling for ConflictCount; the default is the full 16-bit range
  parameter logic [15:0] CNT_MAX  = 16'hFFFF
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        Req1,
  input  logic        Req2,
  input  logic        Wr1,
  input  logic        Wr2,
  input  logic [31:0] Addr1,
  input  logic [31:0] Addr2,
  input  logic [31:0] WData1,
  input  logic [31:0] WData2,
  output logic        Stall,
  output logic        Done1,
  output logic        Done2,
  output logic [31:0] RData1,
  output logic [31:0] RData2,
  output logic        Fault1,
  output logic        Fault2,
  output logic        RE1,
  output logic        RE2,
  output logic        WE1,
  output logic        WE2,
  output logic [31:0] A1,
  output logic [31:0] A2,
  output logic [31:0] WD1,
  output logic [31:0] WD2,
  input  logic [31:0] RD1,
  input  logic [31:0] RD2,
  output logic [15:0] ConflictCount
);

  typedef enum logic {ISSUE, SECOND} state_t;

  state_t      state_q, state_d;
  logic        hwr_q, hwr_d;
  logic [31:0] haddr_q, haddr_d;
  logic [31:0] hwdata_q, hwdata_d;
  logic        done1_q, done1_d, done2_q, done2_d;
  logic        fault1_q, fault1_d, fault2_q, fault2_d;
  logic        ld1_q, ld1_d, ld2_q, ld2_d;
  logic [15:0] cnt_q, cnt_d;

  logic legal1, legal2, conflict;

  assign legal1   = (Addr1 <= ADDR_MAX);
  assign legal2   = (Addr2 <= ADDR_MAX);
  assign conflict = Req1 & Req2 & (Addr1 == Addr2) & (Wr1 | Wr2) & legal1 & legal2;

  // Next-state, memory port drive and completion bookkeeping; all quiet in reset
  always_comb begin
    state_d  = state_q;
    hwr_d    = hwr_q;
    haddr_d  = haddr_q;
    hwdata_d = hwdata_q;
    cnt_d    = cnt_q;
    done1_d  = 1'b0;
    done2_d  = 1'b0;
    fault1_d = 1'b0;
    fault2_d = 1'b0;
    ld1_d    = 1'b0;
    ld2_d    = 1'b0;
    Stall    = 1'b0;
    RE1      = 1'b0;
    WE1      = 1'b0;
    A1       = '0;
    WD1      = '0;
    RE2      = 1'b0;
    WE2      = 1'b0;
    A2       = '0;
    WD2      = '0;
    if (!Reset) begin
      case (state_q)
        ISSUE: begin
          if (Req1) begin
            done1_d  = 1'b1;
            fault1_d = ~legal1;
            if (legal1) begin
              RE1   = ~Wr1;
              WE1   = Wr1;
              A1    = Addr1;
              WD1   = WData1;
              ld1_d = ~Wr1;
            end
          end
          if (conflict) begin
            // lane 2 waits one cycle so lane 1's access lands first
            Stall    = 1'b1;
            hwr_d    = Wr2;
            haddr_d  = Addr2;
            hwdata_d = WData2;
            state_d  = SECOND;
            if (cnt_q != CNT_MAX) cnt_d = cnt_q + 16'd1;
          end else if (Req2) begin
            done2_d  = 1'b1;
            fault2_d = ~legal2;
            if (legal2) begin
              RE2   = ~Wr2;
              WE2   = Wr2;
              A2    = Addr2;
              WD2   = WData2;
              ld2_d = ~Wr2;
            end
          end
        end
        SECOND: begin
          // held lane 2 was range-checked when it was captured
          RE2     = ~hwr_q;
          WE2     = hwr_q;
          A2      = haddr_q;
          WD2     = hwdata_q;
          done2_d = 1'b1;
          ld2_d   = ~hwr_q;
          state_d = ISSUE;
        end
        default: state_d = ISSUE;
      endcase
    end
  end

  // State, holding registers and completion flags
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q  <= ISSUE;
      hwr_q    <= 1'b0;
      haddr_q  <= '0;
      hwdata_q <= '0;
      cnt_q    <= '0;
      done1_q  <= 1'b0;
      done2_q  <= 1'b0;
      fault1_q <= 1'b0;
      fault2_q <= 1'b0;
      ld1_q    <= 1'b0;
      ld2_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      hwr_q    <= hwr_d;
      haddr_q  <= haddr_d;
      hwdata_q <= hwdata_d;
      cnt_q    <= cnt_d;
      done1_q  <= done1_d;
      done2_q  <= done2_d;
      fault1_q <= fault1_d;
      fault2_q <= fault2_d;
      ld1_q    <= ld1_d;
      ld2_q    <= ld2_d;
    end
  end

  // Memory read data is valid the cycle after RE, which is the Done cycle
  assign Done1         = done1_q & ~Reset;
  assign Done2         = done2_q & ~Reset;
  assign Fault1        = fault1_q & ~Reset;
  assign Fault2        = fault2_q & ~Reset;
  assign RData1        = (Done1 && ld1_q) ? RD1 : '0;
  assign RData2        = (Done2 && ld2_q) ? RD2 : '0;
  assign ConflictCount = Reset ? '0 : cnt_q;

endmodule

// File: tb/tb_mem_access_scheduler.sv
// Randomized and directed bench for mem_access_scheduler against a
// transaction-level model (shadow memory updated in program order).
module tb_mem_access_scheduler;

  logic        Clk = 1'b0;
  logic        Reset;
  logic        Req1, Req2, Wr1, Wr2;
  logic [31:0] Addr1, Addr2, WData1, WData2;
  logic        Stall, Done1, Done2, Fault1, Fault2;
  logic [31:0] RData1, RData2;
  logic        RE1, RE2, WE1, WE2;
  logic [31:0] A1, A2, WD1, WD2, RD1, RD2;
  logic [15:0] ConflictCount;

  logic        s_Stall, s_Done1, s_Done2, s_Fault1, s_Fault2;
  logic [31:0] s_RData1, s_RData2;
  logic        s_RE1, s_RE2, s_WE1, s_WE2;
  logic [31:0] s_A1, s_A2, s_WD1, s_WD2;
  logic [15:0] s_Count;

  int total = 0;
  int bad   = 0;

  localparam int unsigned LIMIT   = 999;
  localparam logic [15:0] SAT_MAX = 16'd5;

  logic [31:0] mem [0:1023];
  logic [31:0] sh  [0:1023];
  logic [15:0] exp_cnt;
  logic [15:0] exp_cnt_sat;

  always #5 Clk = ~Clk;

  mem_access_scheduler dut (
    .Clk(Clk), .Reset(Reset), .Req1(Req1), .Req2(Req2), .Wr1(Wr1), .Wr2(Wr2),
    .Addr1(Addr1), .Addr2(Addr2), .WData1(WData1), .WData2(WData2),
    .Stall(Stall), .Done1(Done1), .Done2(Done2), .RData1(RData1), .RData2(RData2),
    .Fault1(Fault1), .Fault2(Fault2), .RE1(RE1), .RE2(RE2), .WE1(WE1), .WE2(WE2),
    .A1(A1), .A2(A2), .WD1(WD1), .WD2(WD2), .RD1(RD1), .RD2(RD2),
    .ConflictCount(ConflictCount)
  );

  // Low-ceiling instance so counter saturation is reachable in a short run
  mem_access_scheduler #(.CNT_MAX(SAT_MAX)) u_sat (
    .Clk(Clk), .Reset(Reset), .Req1(Req1), .Req2(Req2), .Wr1(Wr1), .Wr2(Wr2),
    .Addr1(Addr1), .Addr2(Addr2), .WData1(WData1), .WData2(WData2),
    .Stall(s_Stall), .Done1(s_Done1), .Done2(s_Done2), .RData1(s_RData1), .RData2(s_RData2),
    .Fault1(s_Fault1), .Fault2(s_Fault2), .RE1(s_RE1), .RE2(s_RE2), .WE1(s_WE1), .WE2(s_WE2),
    .A1(s_A1), .A2(s_A2), .WD1(s_WD1), .WD2(s_WD2), .RD1(RD1), .RD2(RD2),
    .ConflictCount(s_Count)
  );

  // Data memory seen by the main instance; reads return junk when RE is low
  always @(posedge Clk) begin
    if (Reset) begin
      for (int i = 0; i < 1024; i++) mem[i] <= 32'(i * 7 + 3);
    end else begin
      if (WE1) mem[A1[9:0]] <= WD1;
      if (WE2) mem[A2[9:0]] <= WD2;
    end
    RD1 <= RE1 ? mem[A1[9:0]] : 32'hDEAD_BEEF;
    RD2 <= RE2 ? mem[A2[9:0]] : 32'hDEAD_BEEF;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] pick_addr();
    case ($urandom_range(0, 9))
      0:       return 32'd1000;
      1:       return 32'd999;
      2:       return 32'hFFFF_FFFF;
      3:       return $urandom;
      default: return 32'($urandom_range(0, 7));
    endcase
  endfunction

  task automatic do_reset();
    @(negedge Clk);
    Reset = 1'b1;
    Req1 = 1'b1; Wr1 = 1'b0; Addr1 = 32'd5; WData1 = 32'h1234;
    Req2 = 1'b1; Wr2 = 1'b1; Addr2 = 32'd5; WData2 = 32'h5678;
    #1;
    check_eq("rst_re1", {31'd0, RE1}, 32'd0);
    check_eq("rst_we2", {31'd0, WE2}, 32'd0);
    check_eq("rst_stall", {31'd0, Stall}, 32'd0);
    check_eq("rst_done2", {31'd0, Done2}, 32'd0);
    check_eq("rst_rdata1", RData1, 32'd0);
    @(negedge Clk);
    #1;
    check_eq("rst_done1", {31'd0, Done1}, 32'd0);
    check_eq("rst_fault1", {31'd0, Fault1}, 32'd0);
    check_eq("rst_cnt", {16'd0, ConflictCount}, 32'd0);
    Reset = 1'b0;
    Req1 = 1'b0; Req2 = 1'b0;
    for (int i = 0; i < 1024; i++) sh[i] = 32'(i * 7 + 3);
    exp_cnt = '0;
    exp_cnt_sat = '0;
    @(posedge Clk);
    #1;
    check_eq("post_rst_done1", {31'd0, Done1}, 32'd0);
  endtask

  // One request pair: drive, check issue cycle, check completion(s)
  task automatic txn(input bit r1, input bit w1, input logic [31:0] a1, input logic [31:0] d1,
                     input bit r2, input bit w2, input logic [31:0] a2, input logic [31:0] d2);
    bit l1, l2, conf, en1, en2;
    logic [31:0] e_rd1, e_rd2;
    @(negedge Clk);
    Req1 = r1; Wr1 = w1; Addr1 = a1; WData1 = d1;
    Req2 = r2; Wr2 = w2; Addr2 = a2; WData2 = d2;
    l1   = (a1 <= LIMIT);
    l2   = (a2 <= LIMIT);
    conf = r1 && r2 && l1 && l2 && (a1 == a2) && (w1 || w2);
    en1  = r1 && l1;
    en2  = r2 && l2 && !conf;
    e_rd1 = (en1 && !w1) ? sh[a1[9:0]] : 32'd0;
    if (en1 && w1) sh[a1[9:0]] = d1;
    e_rd2 = (r2 && l2 && !w2) ? sh[a2[9:0]] : 32'd0;
    if (r2 && l2 && w2) sh[a2[9:0]] = d2;
    if (conf) begin
      if (exp_cnt != 16'hFFFF) exp_cnt++;
      if (exp_cnt_sat != SAT_MAX) exp_cnt_sat++;
    end
    #1;
    check_eq("stall", {31'd0, Stall}, {31'd0, conf});
    check_eq("re1", {31'd0, RE1}, {31'd0, en1 && !w1});
    check_eq("we1", {31'd0, WE1}, {31'd0, en1 && w1});
    check_eq("a1", A1, en1 ? a1 : 32'd0);
    check_eq("wd1", WD1, en1 ? d1 : 32'd0);
    check_eq("re2", {31'd0, RE2}, {31'd0, en2 && !w2});
    check_eq("we2", {31'd0, WE2}, {31'd0, en2 && w2});
    check_eq("a2", A2, en2 ? a2 : 32'd0);
    @(posedge Clk);
    #1;
    check_eq("done1", {31'd0, Done1}, {31'd0, r1});
    check_eq("fault1", {31'd0, Fault1}, {31'd0, r1 && !l1});
    check_eq("rdata1", RData1, e_rd1);
    check_eq("done2", {31'd0, Done2}, {31'd0, r2 && !conf});
    if (!conf) begin
      check_eq("fault2", {31'd0, Fault2}, {31'd0, r2 && !l2});
      check_eq("rdata2", RData2, e_rd2);
    end else begin
      @(negedge Clk);
      #1;
      check_eq("sec_stall", {31'd0, Stall}, 32'd0);
      check_eq("sec_re1", {30'd0, RE1, WE1}, 32'd0);
      check_eq("sec_re2", {31'd0, RE2}, {31'd0, !w2});
      check_eq("sec_we2", {31'd0, WE2}, {31'd0, w2});
      check_eq("sec_a2", A2, a2);
      check_eq("sec_wd2", WD2, d2);
      @(posedge Clk);
      #1;
      check_eq("sec_done2", {31'd0, Done2}, 32'd1);
      check_eq("sec_done1", {31'd0, Done1}, 32'd0);
      check_eq("sec_fault2", {31'd0, Fault2}, 32'd0);
      check_eq("sec_rdata2", RData2, e_rd2);
    end
    check_eq("cnt", {16'd0, ConflictCount}, {16'd0, exp_cnt});
    check_eq("cnt_sat", {16'd0, s_Count}, {16'd0, exp_cnt_sat});
  endtask

  initial begin
    Reset = 1'b1;
    Req1 = 1'b0; Req2 = 1'b0; Wr1 = 1'b0; Wr2 = 1'b0;
    Addr1 = '0; Addr2 = '0; WData1 = '0; WData2 = '0;
    exp_cnt = '0;
    exp_cnt_sat = '0;
    do_reset();

    // Directed scenarios
    txn(1, 0, 32'd5, 32'd0, 1, 0, 32'd7, 32'd0);
    txn(1, 1, 32'd10, 32'hAAAA, 1, 0, 32'd10, 32'd0);
    txn(1, 1, 32'd3, 32'd1, 1, 1, 32'd3, 32'd2);
    txn(1, 0, 32'd3, 32'd0, 0, 0, 32'd0, 32'd0);
    txn(1, 0, 32'd1000, 32'd0, 0, 0, 32'd0, 32'd0);
    txn(1, 0, 32'd4, 32'd0, 1, 0, 32'd4, 32'd0);
    txn(1, 1, 32'd999, 32'h55, 1, 0, 32'd999, 32'd0);
    txn(1, 1, 32'd1000, 32'h66, 1, 1, 32'd1000, 32'h77);
    txn(0, 0, 32'd2, 32'd0, 1, 1, 32'hFFFF_FFFF, 32'h88);

    // Reset arriving while the deferred lane 2 access is pending
    @(negedge Clk);
    Req1 = 1'b1; Wr1 = 1'b1; Addr1 = 32'd20; WData1 = 32'h111;
    Req2 = 1'b1; Wr2 = 1'b1; Addr2 = 32'd20; WData2 = 32'h222;
    #1;
    check_eq("r35_stall", {31'd0, Stall}, 32'd1);
    @(negedge Clk);
    Reset = 1'b1;
    #1;
    check_eq("r35_we2", {30'd0, WE2, RE2}, 32'd0);
    check_eq("r35_done1", {31'd0, Done1}, 32'd0);
    @(posedge Clk);
    #1;
    check_eq("r35_done2", {31'd0, Done2}, 32'd0);
    check_eq("r35_cnt", {16'd0, ConflictCount}, 32'd0);
    @(negedge Clk);
    Reset = 1'b0;
    Req1 = 1'b0; Req2 = 1'b0;
    for (int i = 0; i < 1024; i++) sh[i] = 32'(i * 7 + 3);
    exp_cnt = '0;
    exp_cnt_sat = '0;
    #1;
    check_eq("r35_we2_after", {30'd0, WE2, RE2}, 32'd0);
    txn(1, 0, 32'd20, 32'd0, 1, 0, 32'd21, 32'd0);

    // Randomized traffic
    for (int n = 0; n < 400; n++) begin
      logic [31:0] a1, a2;
      a1 = pick_addr();
      a2 = ($urandom_range(0, 2) == 0) ? a1 : pick_addr();
      txn(1'($urandom), 1'($urandom), a1, $urandom,
          1'($urandom), 1'($urandom), a2, $urandom);
    end

    // Back-to-back conflicts past the low ceiling
    for (int n = 0; n < 8; n++) txn(1, 1, 32'd6, 32'(n), 1, 0, 32'd6, 32'd0);

    do_reset();
    txn(1, 1, 32'd1, 32'h9, 1, 1, 32'd1, 32'hA);
    txn(1, 0, 32'd1, 32'd0, 1, 0, 32'd2, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_access_scheduler.md
MEM_ACCESS_SCHEDULER -- requirements
Module: mem_access_scheduler

Interface
REQ-001 Parameter: ADDR_MAX, 999, highest legal word address of the data memory.
REQ-002 Port: Clk  input  1  single clock; all state changes on rising edge.
REQ-003 Port: Reset  input  1  synchronous, active-high reset.
REQ-004 Port: Req1, Req2  input  1 each  lane request valid (lane 1 = older instruction).
REQ-005 Port: Wr1, Wr2  input  1 each  1 = store, 0 = load.
REQ-006 Port: Addr1, Addr2  input  32 each  word address.
REQ-007 Port: WData1, WData2  input  32 each  store data.
REQ-008 Port: Stall  output  1  pipeline shall hold lane inputs stable while high.
REQ-009 Port: Done1, Done2  output  1 each  one-cycle completion pulse per lane.
REQ-010 Port: RData1, RData2  output  32 each  load result, valid only while matching Done is high and the access was a load.
REQ-011 Port: Fault1, Fault2  output  1 each  out-of-range address flag, valid with Done.
REQ-012 Port: RE1, RE2, WE1, WE2  output  1 each  memory port read/write enables.
REQ-013 Port: A1, A2, WD1, WD2  output  32 each  memory port address/write data.
REQ-014 Port: RD1, RD2  input  32 each  memory read data, valid the cycle after RE.
REQ-015 Port: ConflictCount  output  16  number of split (serialized) request pairs.

Function
REQ-016 FSM states: ISSUE, SECOND; ISSUE after reset.
REQ-017 Conflict: Req1 & Req2 & (Addr1 == Addr2) & (Wr1 | Wr2), both addresses legal.
REQ-018 ISSUE, no conflict: drive each requesting lane's port in the same cycle (RE = ~Wr, WE = Wr, A = Addr, WD = WData); Stall = 0; stay ISSUE.
REQ-019 ISSUE, conflict: issue lane 1 only on port 1, Stall = 1 (combinational, same cycle), capture lane 2 Wr/Addr/WData into holding registers, go to SECOND.
REQ-020 SECOND: issue held lane 2 on port 2, Stall = 0, ignore all lane inputs, return to ISSUE.
REQ-021 Two loads to the same address are not a conflict; both issue in one cycle.
REQ-022 Address > ADDR_MAX: no enable for that lane; lane still completes with Fault = 1 and RData = 0; never participates in a conflict.
REQ-023 Done pulses exactly one cycle after the lane's issue cycle (non-conflict: both Done together; conflict: Done1 at T+1, Done2 at T+2).
REQ-024 RData = RD of the lane's port when Done and load, else 0.
REQ-025 Unused port: RE = WE = 0, A = WD = 0.
REQ-026 ConflictCount increments by 1 on each ISSUE->SECOND transition, saturates at 0xFFFF.
REQ-027 Req low on a lane: no enable, no Done for that lane.

Reset
REQ-028 While Reset high: all enables 0, Stall 0, Done/Fault 0, RData 0, state ISSUE, holding registers 0, ConflictCount 0.
REQ-029 Reset asserted in SECOND: deferred lane 2 access is discarded (never issued, no Done2).
REQ-030 Request inputs present during the Reset cycle are ignored; first issue is the cycle after Reset falls.

Verification
REQ-031 Load Addr1=5, load Addr2=7, no conflict -> RE1=RE2=1 same cycle, Done1=Done2=1 next cycle, RData = stored words, Stall stays 0.
REQ-032 Store Addr1=10 WData1=0xAAAA, load Addr2=10 -> Stall=1 one cycle, WE1 then RE2 next cycle, Done1 T+1, Done2 T+2 with RData2=0xAAAA, ConflictCount=1.
REQ-033 Store Addr1=3 val 1, store Addr2=3 val 2 -> serialized, memory word 3 = 2 after Done2.
REQ-034 Load Addr1=1000 -> no RE1, Done1 next cycle with Fault1=1, RData1=0.
REQ-035 Conflict cycle then Reset high during SECOND -> no WE2/RE2, no Done2, state ISSUE, ConflictCount=0.
REQ-036 Force 65536 conflicts -> ConflictCount holds 0xFFFF.
